// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencer and its LFSR.
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      WAIT  = 3'd2,
      REACT = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int          MS_W      = 14;

   // Right-shifting Galois step for x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

endpackage

// File: rtl/lfsr_16.sv
// Free-running 16-bit Galois LFSR; loads the seed on reset and never reaches zero from a nonzero seed.
module lfsr_16
   import reaction_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      if (reset) q <= seed;
      else       q <= lfsr_next(q);
   end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer driving the delay_16 stage and measuring response time in ms.
// Optional best-time tracking is enabled with REACTION_BEST_EN.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// ARM   | one cycle: load N from the LFSR
// WAIT  | trigger held high until time_out, stop here is a cheat
// REACT | led lit, counting tick_ms until stop or saturation
// DONE  | result held until start
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter logic [15:0]     MIN_DELAY = 16'd1000,
   parameter logic [15:0]     RAND_MASK = 16'h0FFF,
   parameter logic [MS_W-1:0] MAX_MS    = 14'd9999,
   parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            stop,
   input  logic            tick_ms,
   input  logic            time_out,
   output logic            trigger,
   output logic [15:0]     N,
   output logic            led,
   output logic [MS_W-1:0] react_ms,
   output logic            valid,
   output logic            cheat,
   output logic            over
`ifdef REACTION_BEST_EN
   ,
   output logic [MS_W-1:0] best_ms
`endif
);

   state_t          r_state;
   state_t          w_next;
   logic [15:0]     w_lfsr;
   logic [15:0]     r_n;
   logic [MS_W-1:0] r_cnt;
   logic [MS_W-1:0] r_react;
   logic            r_valid;
   logic            r_cheat;
   logic            r_over;
   logic            w_sat;

   lfsr_16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (w_lfsr)
   );

   // Saturation fires on the tick that would bring the count to MAX_MS
   assign w_sat = tick_ms && (r_cnt == (MAX_MS - 14'd1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      trigger = 1'b0;
      led     = 1'b0;
      case (r_state)
         IDLE:  if (start) w_next = ARM;
         ARM:   w_next = WAIT;
         WAIT: begin
            trigger = 1'b1;
            if (stop)          w_next = DONE;
            else if (time_out) w_next = REACT;
         end
         REACT: begin
            led = 1'b1;
            if (stop || w_sat) w_next = DONE;
         end
         DONE:  if (start) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_n     <= '0;
         r_cnt   <= '0;
         r_react <= '0;
         r_valid <= 1'b0;
         r_cheat <= 1'b0;
         r_over  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_react <= '0;
                  r_valid <= 1'b0;
                  r_cheat <= 1'b0;
                  r_over  <= 1'b0;
               end
            end
            ARM: r_n <= MIN_DELAY + (w_lfsr & RAND_MASK);
            WAIT: begin
               r_cnt <= '0;
               if (stop) begin
                  r_cheat <= 1'b1;
                  r_react <= '0;
                  r_valid <= 1'b0;
               end
            end
            REACT: begin
               if (stop) begin
                  r_react <= r_cnt;
                  r_valid <= 1'b1;
               end else if (w_sat) begin
                  r_react <= MAX_MS;
                  r_over  <= 1'b1;
               end else if (tick_ms) begin
                  r_cnt <= r_cnt + 14'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef REACTION_BEST_EN
   logic [MS_W-1:0] r_best;

   always_ff @(posedge clk) begin
      if (reset)                              r_best <= MAX_MS;
      else if (r_valid && (r_react < r_best)) r_best <= r_react;
   end

   assign best_ms = r_best;
`endif

   assign N        = r_n;
   assign react_ms = r_react;
   assign valid    = r_valid;
   assign cheat    = r_cheat;
   assign over     = r_over;

endmodule
